// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone command initiator: FSM state encoding and
// the completion status recorded for each transfer.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK  = 2'd0,
        RSP_ERR = 2'd1,
        RSP_TMO = 2'd2
    } rsp_status_t;

endpackage

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer master: one command in, one WB cycle out,
// one response back. Handshakes follow valid/ready; a beat moves when both are high.
module wb_cmd_initiator
    import wb_cmd_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            rsp_tmo_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    output logic            busy_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t            state, state_nxt;
    logic              in_idle, in_bus, in_resp;
    logic              tmo_hit, bus_done;

    logic              lat_we;
    logic [AW-1:0]     lat_adr;
    logic [DW-1:0]     lat_dat;
    logic [DW/8-1:0]   lat_sel;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [DW-1:0]     rsp_dat;
    rsp_status_t       rsp_status;

    assign in_idle  = (state == ST_IDLE);
    assign in_bus   = (state == ST_BUS);
    assign in_resp  = (state == ST_RESP);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign bus_done = wbm_ack_i | wbm_err_i | tmo_hit;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid_i) state_nxt = ST_BUS;
            ST_BUS:  if (bus_done)    state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Command capture, timeout counting and response capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lat_we     <= 1'b0;
            lat_adr    <= '0;
            lat_dat    <= '0;
            lat_sel    <= '0;
            tmo_cnt    <= '0;
            rsp_dat    <= '0;
            rsp_status <= RSP_OK;
        end else if (in_idle && cmd_valid_i) begin
            lat_we  <= cmd_we_i;
            lat_adr <= cmd_adr_i;
            lat_dat <= cmd_dat_i;
            lat_sel <= cmd_sel_i;
            tmo_cnt <= '0;
        end else if (in_bus) begin
            // err beats ack, and either beats a timeout landing in the same cycle
            if (wbm_err_i) begin
                rsp_dat    <= '0;
                rsp_status <= RSP_ERR;
            end else if (wbm_ack_i) begin
                rsp_dat    <= lat_we ? '0 : wbm_dat_i;
                rsp_status <= RSP_OK;
            end else if (tmo_hit) begin
                rsp_dat    <= '0;
                rsp_status <= RSP_TMO;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign cmd_ready_o = in_idle;
    assign busy_o      = !in_idle;

    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus & lat_we;
    assign wbm_sel_o = in_bus ? lat_sel : '0;
    assign wbm_adr_o = in_bus ? lat_adr : '0;
    assign wbm_dat_o = in_bus ? lat_dat : '0;

    assign rsp_valid_o = in_resp;
    assign rsp_dat_o   = in_resp ? rsp_dat : '0;
    assign rsp_err_o   = in_resp && (rsp_status == RSP_ERR);
    assign rsp_tmo_o   = in_resp && (rsp_status == RSP_TMO);

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: transaction-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_wb_cmd_initiator;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TMO_CYC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          rsp_tmo;
  logic          wbm_cyc;
  logic          wbm_stb;
  logic          wbm_we;
  logic [SW-1:0] wbm_sel;
  logic [AW-1:0] wbm_adr;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] wbm_dat_i = '0;
  logic          wbm_ack = 1'b0;
  logic          wbm_err = 1'b0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  wb_cmd_initiator #(.AW(AW), .DW(DW), .TMO_W(8), .TMO_CYC(TMO_CYC)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .rsp_tmo_o   (rsp_tmo),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack),
    .wbm_err_i   (wbm_err),
    .busy_o      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          err;
    logic          tmo;
  } rsp_t;

  bit   model_live  = 0;
  bit   m_in_flight = 0;
  bit   m_have_rsp  = 0;
  cmd_t m_cmd;
  rsp_t m_rsp;
  int   m_elapsed   = 0;
  int   stb_run     = 0;
  int   last_stb_len = 0;
  int   accept_cnt  = 0;

  always @(negedge clk) begin
    if (model_live) begin
      check("cmd_ready", cmd_ready, !(m_in_flight || m_have_rsp));
      check("busy",      busy,      m_in_flight || m_have_rsp);
      check("cyc",       wbm_cyc,   m_in_flight);
      check("stb",       wbm_stb,   m_in_flight);
      check("we",        wbm_we,    m_in_flight ? m_cmd.we  : 1'b0);
      check("sel",       wbm_sel,   m_in_flight ? m_cmd.sel : '0);
      check("adr",       wbm_adr,   m_in_flight ? m_cmd.adr : '0);
      check("dat_o",     wbm_dat_o, m_in_flight ? m_cmd.dat : '0);
      check("rsp_valid", rsp_valid, m_have_rsp);
      if (m_have_rsp) begin
        check("rsp_dat", rsp_dat, m_rsp.dat);
        check("rsp_err", rsp_err, m_rsp.err);
        check("rsp_tmo", rsp_tmo, m_rsp.tmo);
      end
    end

    if (wbm_stb) stb_run++;
    else if (stb_run > 0) begin
      last_stb_len = stb_run;
      stb_run = 0;
    end
    if (cmd_valid && cmd_ready) accept_cnt++;

    // Advance the model with the inputs the next rising edge will sample.
    if (rst) begin
      m_in_flight = 0;
      m_have_rsp  = 0;
      model_live  = 1;
    end else if (m_have_rsp) begin
      if (rsp_ready) m_have_rsp = 0;
    end else if (m_in_flight) begin
      if (wbm_err) begin
        m_rsp = '{dat: '0, err: 1'b1, tmo: 1'b0};
        m_have_rsp = 1;
      end else if (wbm_ack) begin
        m_rsp = '{dat: (m_cmd.we ? '0 : wbm_dat_i), err: 1'b0, tmo: 1'b0};
        m_have_rsp = 1;
      end else if (m_elapsed + 1 == TMO_CYC) begin
        m_rsp = '{dat: '0, err: 1'b0, tmo: 1'b1};
        m_have_rsp = 1;
      end else begin
        m_elapsed++;
      end
      if (m_have_rsp) m_in_flight = 0;
    end else if (cmd_valid) begin
      m_cmd = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
      m_elapsed = 0;
      m_in_flight = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic slave_reply(input logic ack, input logic err, input logic [DW-1:0] dat);
    wbm_ack = ack; wbm_err = err; wbm_dat_i = dat;
    tick();
    wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat_i = '0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) tick();
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_cyc",       wbm_cyc,   1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_busy",      busy,      1'b0);
    rst = 1'b0;
    tick();

    // Read, ack on the third strobe cycle.
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    check("read_stb_latency", wbm_stb, 1'b1);
    tick(); tick();
    slave_reply(1'b1, 1'b0, 32'hDEAD_BEEF);
    check("read_rsp_valid", rsp_valid, 1'b1);
    check("read_rsp_dat",   rsp_dat,   32'hDEAD_BEEF);
    check("read_rsp_flags", {rsp_err, rsp_tmo}, 2'b00);
    tick();
    check("read_stb_width", last_stb_len, 3);

    // Write with immediate ack.
    issue(1'b1, 32'h3000_0004, 32'h1234_5678, 4'b0011);
    check("write_adr", wbm_adr,   32'h3000_0004);
    check("write_dat", wbm_dat_o, 32'h1234_5678);
    check("write_sel", wbm_sel,   4'b0011);
    check("write_we",  wbm_we,    1'b1);
    slave_reply(1'b1, 1'b0, 32'hFFFF_FFFF);
    check("write_rsp_valid", rsp_valid, 1'b1);
    check("write_rsp_dat",   rsp_dat,   32'h0);
    tick();

    // ack and err together: err wins.
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    slave_reply(1'b1, 1'b1, 32'hCAFE_F00D);
    check("err_flag", rsp_err, 1'b1);
    check("err_dat",  rsp_dat, 32'h0);
    tick();

    // Silent slave: timeout after exactly TMO_CYC strobe cycles.
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    check("tmo_wait",  rsp_valid, 1'b1);
    check("tmo_flag",  rsp_tmo,   1'b1);
    check("tmo_dat",   rsp_dat,   32'h0);
    tick();
    check("tmo_stb_width", last_stb_len, TMO_CYC);

    // Ack on the last permitted cycle beats the timeout.
    issue(1'b0, 32'h3000_0034, 32'h0, 4'hF);
    repeat (TMO_CYC - 1) tick();
    slave_reply(1'b1, 1'b0, 32'hA5A5_A5A5);
    check("late_ack_tmo", rsp_tmo, 1'b0);
    check("late_ack_dat", rsp_dat, 32'hA5A5_A5A5);
    tick();
    check("late_ack_stb_width", last_stb_len, TMO_CYC);

    // Response backpressure with a stray ack and a waiting command.
    rsp_ready = 1'b0;
    issue(1'b1, 32'h3000_0008, 32'h0BAD_CAFE, 4'b1100);
    slave_reply(1'b1, 1'b0, 32'h0);
    cmd_valid = 1'b1;
    cmd_adr = 32'h3000_00FF;
    tick();
    slave_reply(1'b1, 1'b0, 32'h1111_1111);
    repeat (2) tick();
    check("bp_cmd_ready", cmd_ready, 1'b0);
    check("bp_rsp_valid", rsp_valid, 1'b1);
    check("bp_rsp_dat",   rsp_dat,   32'h0);
    cmd_valid = 1'b0;
    tick();
    rsp_ready = 1'b1;
    tick();
    check("bp_released", cmd_ready, 1'b1);

    // Back-to-back with ack held high: one command per three cycles.
    accept_cnt = 0;
    cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    wbm_ack = 1'b1;
    repeat (9) tick();
    cmd_valid = 1'b0;
    wbm_ack = 1'b0;
    check("b2b_accepts", accept_cnt, 3);

    // Reset in the middle of a bus cycle.
    tick();
    issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_cyc",       wbm_cyc,   1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    tick();
    issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
    slave_reply(1'b1, 1'b0, 32'h7777_0001);
    check("post_rst_dat", rsp_dat, 32'h7777_0001);
    tick();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
